// File: rtl/ifetch_pkg.sv
// Shared types and defaults for the instruction-fetch sequencer.
// IFETCH_PERF_EN (define) enables the fetch/flush performance counters in inst_fetch_ctrl.
package ifetch_pkg;
  localparam int          AW_DEF       = 6;
  localparam int          DW_DEF       = 32;
  localparam logic [5:0]  RESET_PC_DEF = 6'h01;
  localparam logic [31:0] NOP          = 32'h0;
  localparam int          PERF_W       = 16;

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_HALT  = 1'b1
  } if_state_e;

  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    return (&v) ? v : v + PERF_W'(1);
  endfunction
endpackage

// File: rtl/ifetch_fifo.sv
// Small synchronous FIFO holding {pc, inst} pairs; flush beats push/pop.
module ifetch_fifo #(
  parameter int W     = 38,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  din,
  output logic [CW-1:0] count,
  output logic [W-1:0]  head
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_q, wr_q;

  // DEPTH is a power of two, so pointers wrap for free
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      rd_q  <= '0;
      wr_q  <= '0;
      count <= '0;
    end else begin
      if (push) wr_q <= wr_q + PW'(1);
      if (pop)  rd_q <= rd_q + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && !flush && push) mem[wr_q] <= din;
  end

  assign head = mem[rd_q];
endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, fetches from a combinational ROM, feeds decode.
// IFETCH_PERF_EN (define) adds saturating fetch_cnt / flush_cnt outputs.
module inst_fetch_ctrl
  import ifetch_pkg::*;
#(
  parameter int            AW       = AW_DEF,
  parameter int            DW       = DW_DEF,
  parameter int            DEPTH    = 2,
  parameter logic [AW-1:0] RESET_PC = AW'(RESET_PC_DEF)
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_inst,
  output logic          if_valid,
  input  logic          if_ready,
  output logic [DW-1:0] if_inst,
  output logic [AW-1:0] if_pc,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc,
  input  logic          halt_req,
  output logic          halted
`ifdef IFETCH_PERF_EN
  ,
  output logic [PERF_W-1:0] fetch_cnt,
  output logic [PERF_W-1:0] flush_cnt
`endif
);
  localparam int CW = $clog2(DEPTH) + 1;

  if_state_e        state_q, state_d;
  logic [AW-1:0]    pc_q;
  logic [CW-1:0]    count;
  logic [AW+DW-1:0] head;
  logic             push, pop;

  // redirect squashes both sides of the handshake
  assign pop  = if_valid & if_ready & ~redirect_valid;
  assign push = (state_q == ST_FETCH) & ~halt_req & ~redirect_valid &
                ((count < CW'(DEPTH)) | pop);

  ifetch_fifo #(.W(AW+DW), .DEPTH(DEPTH), .CW(CW)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   ({pc_q, rom_inst}),
    .count (count),
    .head  (head)
  );

  always_ff @(posedge clk) begin
    if (!rst_n)              pc_q <= RESET_PC;
    else if (redirect_valid) pc_q <= redirect_pc;
    else if (push)           pc_q <= pc_q + AW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH: if (halt_req)  state_d = ST_HALT;
      ST_HALT:  if (!halt_req) state_d = ST_FETCH;
      default:  state_d = ST_FETCH;
    endcase
  end

  always_comb begin
    if_valid = (count != '0);
    halted   = (state_q == ST_HALT) && !if_valid;
    if_pc    = if_valid ? head[AW+DW-1:DW] : '0;
    if_inst  = if_valid ? head[DW-1:0]     : DW'(NOP);
  end

  assign rom_addr = pc_q;

`ifdef IFETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (push)                      fetch_cnt <= sat_inc(fetch_cnt);
      if (redirect_valid && if_valid) flush_cnt <= sat_inc(flush_cnt);
    end
  end
`endif
endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Bench for inst_fetch_ctrl: vector table, directed corner sequences, random run vs queue model.
module tb_inst_fetch_ctrl;
  import ifetch_pkg::*;
  localparam int AW = 6, DW = 32, DEPTH = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_inst;
  logic          if_valid;
  logic          if_ready = 1'b0;
  logic [DW-1:0] if_inst;
  logic [AW-1:0] if_pc;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          halt_req = 1'b0;
  logic          halted;
`ifdef IFETCH_PERF_EN
  logic [15:0]   fetch_cnt, flush_cnt;
`endif

  inst_fetch_ctrl #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .RESET_PC(6'h01)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rom_addr       (rom_addr),
    .rom_inst       (rom_inst),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_inst        (if_inst),
    .if_pc          (if_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_req       (halt_req),
    .halted         (halted)
`ifdef IFETCH_PERF_EN
    ,
    .fetch_cnt      (fetch_cnt),
    .flush_cnt      (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  // every word distinct and nonzero, so a wrong PC shows up in the data too
  function automatic logic [DW-1:0] rom_f(input logic [AW-1:0] a);
    return {2'b10, a, 8'h5A, a, 2'b01, a ^ 6'h2A, 2'b11};
  endfunction

  assign rom_inst = rom_f(rom_addr);

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference: a queue of fetched {pc,inst}, a PC and a halt flag
  logic [AW+DW-1:0] mq[$];
  logic [AW-1:0]    m_pc = 6'h01;
  bit               m_halt = 0;
  int               m_fc = 0, m_flc = 0;

  task automatic model_update(input bit r, input bit rdy, input bit rv,
                              input logic [AW-1:0] rpc, input bit h);
    bit pop, push;
    if (!r) begin
      mq.delete();
      m_pc = 6'h01; m_halt = 0; m_fc = 0; m_flc = 0;
    end else begin
      if (rv) begin
        if (mq.size() > 0 && m_flc < 65535) m_flc++;
        mq.delete();
        m_pc = rpc;
      end else begin
        pop  = (mq.size() > 0) && rdy;
        push = !m_halt && !h && ((mq.size() < DEPTH) || pop);
        if (pop) void'(mq.pop_front());
        if (push) begin
          mq.push_back({m_pc, rom_f(m_pc)});
          m_pc = m_pc + 6'd1;
          if (m_fc < 65535) m_fc++;
        end
      end
      m_halt = h;
    end
  endtask

  task automatic compare_model();
    bit            ev;
    logic [AW-1:0] epc;
    logic [DW-1:0] ein;
    ev  = mq.size() != 0;
    epc = ev ? mq[0][AW+DW-1:DW] : '0;
    ein = ev ? mq[0][DW-1:0] : '0;
    chk("model if_valid", 64'(if_valid), 64'(ev));
    chk("model if_pc",    64'(if_pc),    64'(epc));
    chk("model if_inst",  64'(if_inst),  64'(ein));
    chk("model rom_addr", 64'(rom_addr), 64'(m_pc));
    chk("model halted",   64'(halted),   64'(m_halt && !ev));
`ifdef IFETCH_PERF_EN
    chk("model fetch_cnt", 64'(fetch_cnt), 64'(m_fc));
    chk("model flush_cnt", 64'(flush_cnt), 64'(m_flc));
`endif
  endtask

  task automatic step(input bit r, input bit rdy, input bit rv,
                      input logic [AW-1:0] rpc, input bit h);
    rst_n = r; if_ready = rdy; redirect_valid = rv; redirect_pc = rpc; halt_req = h;
    @(posedge clk);
    model_update(r, rdy, rv, rpc, h);
    #1;
    compare_model();
  endtask

  typedef struct {
    bit r, rdy, rv; logic [AW-1:0] rpc; bit h;
    bit ev; logic [AW-1:0] epc, eaddr; bit ehl;
  } vec_t;

  function automatic vec_t mk(bit r, bit rdy, bit rv, logic [AW-1:0] rpc, bit h,
                              bit ev, logic [AW-1:0] epc, logic [AW-1:0] eaddr, bit ehl);
    vec_t v;
    v.r = r; v.rdy = rdy; v.rv = rv; v.rpc = rpc; v.h = h;
    v.ev = ev; v.epc = epc; v.eaddr = eaddr; v.ehl = ehl;
    return v;
  endfunction

  vec_t tbl[14];

  initial begin
    logic [AW-1:0] held;
    bit h;

    // expected outputs after each row's clock edge
    tbl[0]  = mk(0,1,0,6'h00,0, 0,6'h00,6'h01,0);
    tbl[1]  = mk(0,1,0,6'h00,0, 0,6'h00,6'h01,0);
    tbl[2]  = mk(1,1,0,6'h00,0, 1,6'h01,6'h02,0);
    tbl[3]  = mk(1,1,0,6'h00,0, 1,6'h02,6'h03,0);
    tbl[4]  = mk(1,1,0,6'h00,0, 1,6'h03,6'h04,0);
    tbl[5]  = mk(1,0,0,6'h00,0, 1,6'h03,6'h05,0);
    tbl[6]  = mk(1,0,0,6'h00,0, 1,6'h03,6'h05,0);
    tbl[7]  = mk(1,0,0,6'h00,0, 1,6'h03,6'h05,0);
    tbl[8]  = mk(1,1,1,6'h0A,0, 0,6'h00,6'h0A,0);
    tbl[9]  = mk(1,1,0,6'h00,0, 1,6'h0A,6'h0B,0);
    tbl[10] = mk(1,1,0,6'h00,0, 1,6'h0B,6'h0C,0);
    tbl[11] = mk(1,1,0,6'h00,1, 0,6'h00,6'h0C,1);
    tbl[12] = mk(1,1,0,6'h00,0, 0,6'h00,6'h0C,0);
    tbl[13] = mk(1,1,0,6'h00,0, 1,6'h0C,6'h0D,0);

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].rdy, tbl[i].rv, tbl[i].rpc, tbl[i].h);
      chk($sformatf("vec%0d if_valid", i), 64'(if_valid), 64'(tbl[i].ev));
      chk($sformatf("vec%0d if_pc", i),    64'(if_pc),    64'(tbl[i].epc));
      chk($sformatf("vec%0d if_inst", i),  64'(if_inst),
          64'(tbl[i].ev ? rom_f(tbl[i].epc) : 32'h0));
      chk($sformatf("vec%0d rom_addr", i), 64'(rom_addr), 64'(tbl[i].eaddr));
      chk($sformatf("vec%0d halted", i),   64'(halted),   64'(tbl[i].ehl));
    end

    // backpressure: FIFO fills with 1,2 and the PC parks at 3
    step(0,0,0,'0,0);
    repeat (5) step(1,0,0,'0,0);
    chk("hold rom_addr", 64'(rom_addr), 64'(6'h03));
    chk("hold head pc",  64'(if_pc),    64'(6'h01));
    step(1,1,0,'0,0);
    chk("release pc2", 64'(if_pc), 64'(6'h02));
    step(1,1,0,'0,0);
    chk("release pc3", 64'(if_pc), 64'(6'h03));
    chk("release inst3", 64'(if_inst), 64'(rom_f(6'h03)));

    // redirect to the top word and watch the PC wrap
    step(1,1,1,6'h3F,0);
    chk("wrap flush valid", 64'(if_valid), 64'(1'b0));
    step(1,1,0,'0,0);
    chk("wrap pc 3F", 64'(if_pc), 64'(6'h3F));
    step(1,1,0,'0,0);
    chk("wrap pc 00", 64'(if_pc), 64'(6'h00));
    step(1,1,0,'0,0);
    chk("wrap pc 01", 64'(if_pc), 64'(6'h01));

    // halt for 6 cycles while decode drains, then resume at the held PC
    held = m_pc;
    repeat (6) step(1,1,0,'0,1);
    chk("halt halted", 64'(halted), 64'(1'b1));
    chk("halt rom_addr", 64'(rom_addr), 64'(held));
    step(1,1,0,'0,0);
    chk("unhalt halted", 64'(halted), 64'(1'b0));
    step(1,1,0,'0,0);
    chk("resume pc", 64'(if_pc), 64'(held));

    // reset while full
    repeat (3) step(1,0,0,'0,0);
    chk("prefill full", 64'(mq.size()), 64'(DEPTH));
    step(0,0,0,'0,0);
    chk("rst valid", 64'(if_valid), 64'(1'b0));
    chk("rst rom_addr", 64'(rom_addr), 64'(6'h01));

    // random traffic
    h = 0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 9) == 0) h = !h;
      step($urandom_range(0, 199) != 0, $urandom_range(0, 2) != 0,
           $urandom_range(0, 11) == 0, AW'($urandom), h);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
